hall_call_dispatcher: RTL and testbench

HALL_CALL_DISPATCHER -- requirements
Module: hall_call_dispatcher

---
 rtl/hall_call_dispatcher_pkg.sv | 39 +++
 rtl/hall_call_dispatcher_dispatch_cost.sv | 22 ++
 rtl/hall_call_dispatcher.sv | 200 ++++++++++++++++++++
 tb/tb_hall_call_dispatcher.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/hall_call_dispatcher_pkg.sv
// Shared types, motion codes and the hall-call slot table for the dispatcher.
package hall_call_dispatcher_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StOffer,
    StWait
  } disp_state_t;

  // Car motion encoding on carN_ac
  localparam logic [1:0] AcDown = 2'd0;
  localparam logic [1:0] AcStop = 2'd1;
  localparam logic [1:0] AcUp   = 2'd2;

  // Added to the distance when a car is travelling away from the target
  localparam logic [2:0] AwayPenalty = 3'd4;

  // Slots 0..2 are up calls at floors 1..3, slots 3..5 are down calls at floors 2..4
  function automatic logic [1:0] slot_floor(input logic [2:0] slot);
    logic [1:0] floor_code;
    unique case (slot)
      3'd0:    floor_code = 2'd0;
      3'd1:    floor_code = 2'd1;
      3'd2:    floor_code = 2'd2;
      3'd3:    floor_code = 2'd1;
      3'd4:    floor_code = 2'd2;
      3'd5:    floor_code = 2'd3;
      default: floor_code = 2'd0;
    endcase
    return floor_code;
  endfunction

  // 1 = up call, 0 = down call
  function automatic logic slot_dir(input logic [2:0] slot);
    return (slot < 3'd3);
  endfunction

endpackage

// File: rtl/hall_call_dispatcher_dispatch_cost.sv
// Combinational cost of sending one car to a target floor.
module dispatch_cost
  import hall_call_dispatcher_pkg::*;
(
  input  logic [1:0] i_floor,
  input  logic [1:0] i_ac,
  input  logic [1:0] i_target,
  output logic [2:0] o_cost
);

  logic [1:0] w_dist;
  logic       w_away;

  // Distance plus a fixed penalty when the car heads the wrong way; max 3 + 4 = 7
  always_comb begin
    w_dist = (i_floor >= i_target) ? (i_floor - i_target) : (i_target - i_floor);
    w_away = ((i_ac == AcUp) && (i_target < i_floor)) ||
             ((i_ac == AcDown) && (i_target > i_floor));
    o_cost = {1'b0, w_dist} + (w_away ? AwayPenalty : 3'd0);
  end

endmodule

// File: rtl/hall_call_dispatcher.sv
// Two-car hall-call dispatcher: latches calls, offers them round-robin to the cheaper car.
module hall_call_dispatcher
  import hall_call_dispatcher_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 15,
  parameter int unsigned NCALL       = 6
) (
  input  logic       clk,
  input  logic       ff_reset,
  input  logic [2:0] i_up_call,
  input  logic [2:0] i_dn_call,
  input  logic [1:0] i_car0_floor,
  input  logic [1:0] i_car0_ac,
  input  logic       i_car0_open,
  input  logic       i_car0_ack,
  input  logic [1:0] i_car1_floor,
  input  logic [1:0] i_car1_ac,
  input  logic       i_car1_open,
  input  logic       i_car1_ack,
  output logic       o_car0_valid,
  output logic [1:0] o_car0_floor_req,
  output logic       o_car0_dir_req,
  output logic       o_car1_valid,
  output logic [1:0] o_car1_floor_req,
  output logic       o_car1_dir_req,
  output logic [2:0] o_lamp_up,
  output logic [2:0] o_lamp_dn
);

  disp_state_t      r_state;
  logic [NCALL-1:0] r_pending;
  logic [NCALL-1:0] r_assigned;
  logic [2:0]       r_last_slot;
  logic             r_last_car;
  logic [3:0]       r_timer;
  logic [2:0]       r_slot;
  logic             r_car;
  logic             r_valid0;
  logic             r_valid1;
  logic [1:0]       r_floor_req;
  logic             r_dir_req;

  logic [NCALL-1:0] w_set;
  logic [NCALL-1:0] w_clear;
  logic [NCALL-1:0] w_cand;
  logic [NCALL-1:0] w_assign_set;
  logic             w_found;
  logic [2:0]       w_pick;
  int unsigned      w_idx;
  logic [1:0]       w_target;
  logic [2:0]       w_cost0;
  logic [2:0]       w_cost1;
  logic             w_pick_car;
  logic             w_ack;
  logic             w_slot_gone;

  assign w_set  = {i_dn_call, i_up_call};
  assign w_cand = r_pending & ~r_assigned;

  // A slot is serviced when any car is stopped with its door open at that floor
  always_comb begin
    w_clear = '0;
    for (int s = 0; s < NCALL; s++) begin
      w_clear[s] = ((i_car0_floor == slot_floor(3'(s))) && i_car0_open && (i_car0_ac == AcStop)) ||
                   ((i_car1_floor == slot_floor(3'(s))) && i_car1_open && (i_car1_ac == AcStop));
    end
  end

  // Round-robin search from last_slot+1; iterating downward lets the nearest slot win
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = 0;
    for (int i = NCALL - 1; i >= 0; i--) begin
      w_idx = int'(r_last_slot) + 1 + i;
      if (w_idx >= NCALL) w_idx = w_idx - NCALL;
      if (w_cand[w_idx]) begin
        w_found = 1'b1;
        w_pick  = 3'(w_idx);
      end
    end
  end

  assign w_target = slot_floor(w_pick);

  dispatch_cost u_cost0 (
    .i_floor  (i_car0_floor),
    .i_ac     (i_car0_ac),
    .i_target (w_target),
    .o_cost   (w_cost0)
  );

  dispatch_cost u_cost1 (
    .i_floor  (i_car1_floor),
    .i_ac     (i_car1_ac),
    .i_target (w_target),
    .o_cost   (w_cost1)
  );

  // Cheaper car wins; a tie goes to the car that was not served last
  always_comb begin
    if (w_cost1 < w_cost0)      w_pick_car = 1'b1;
    else if (w_cost0 < w_cost1) w_pick_car = 1'b0;
    else                        w_pick_car = ~r_last_car;
  end

  assign w_ack       = r_car ? i_car1_ack : i_car0_ack;
  assign w_slot_gone = w_clear[r_slot] | ~r_pending[r_slot];

  // Acknowledged offers mark their slot assigned, unless the slot is cleared the same cycle
  always_comb begin
    w_assign_set = '0;
    if ((r_state == StWait) && w_ack && !w_slot_gone) w_assign_set[r_slot] = 1'b1;
  end

  // Pending and assigned bits; clear wins over a simultaneous set
  always_ff @(posedge clk or posedge ff_reset) begin
    if (ff_reset) begin
      r_pending  <= '0;
      r_assigned <= '0;
    end else begin
      r_pending  <= (r_pending | w_set) & ~w_clear;
      r_assigned <= (r_assigned | w_assign_set) & ~w_clear;
    end
  end

  // Dispatch FSM with registered offer outputs
  always_ff @(posedge clk or posedge ff_reset) begin
    if (ff_reset) begin
      r_state     <= StIdle;
      r_last_slot <= 3'd5;
      r_last_car  <= 1'b1;
      r_timer     <= '0;
      r_slot      <= '0;
      r_car       <= 1'b0;
      r_valid0    <= 1'b0;
      r_valid1    <= 1'b0;
      r_floor_req <= '0;
      r_dir_req   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (|w_cand) r_state <= StScan;
        end
        StScan: begin
          if (w_found) begin
            r_state     <= StOffer;
            r_slot      <= w_pick;
            r_car       <= w_pick_car;
            r_floor_req <= w_target;
            r_dir_req   <= slot_dir(w_pick);
            r_valid0    <= ~w_pick_car;
            r_valid1    <= w_pick_car;
          end else begin
            r_state <= StIdle;
          end
        end
        StOffer: begin
          r_state <= StWait;
          r_timer <= '0;
        end
        StWait: begin
          if (w_slot_gone) begin
            r_valid0 <= 1'b0;
            r_valid1 <= 1'b0;
            r_timer  <= '0;
            r_state  <= StIdle;
          end else if (w_ack) begin
            r_valid0    <= 1'b0;
            r_valid1    <= 1'b0;
            r_last_car  <= r_car;
            r_last_slot <= r_slot;
            r_timer     <= '0;
            r_state     <= StIdle;
          end else if (r_timer == 4'(ACK_TIMEOUT - 1)) begin
            // Offer has waited ACK_TIMEOUT cycles in WAIT; leave the slot for a later pass
            r_valid0    <= 1'b0;
            r_valid1    <= 1'b0;
            r_last_slot <= r_slot;
            r_timer     <= '0;
            r_state     <= StIdle;
          end else begin
            r_timer <= r_timer + 4'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_car0_valid     = r_valid0;
  assign o_car1_valid     = r_valid1;
  assign o_car0_floor_req = r_floor_req;
  assign o_car1_floor_req = r_floor_req;
  assign o_car0_dir_req   = r_dir_req;
  assign o_car1_dir_req   = r_dir_req;
  assign o_lamp_up        = r_pending[2:0];
  assign o_lamp_dn        = r_pending[5:3];

endmodule

// File: tb/tb_hall_call_dispatcher.sv
// Directed bench for hall_call_dispatcher with hand-computed expectations.
module tb_hall_call_dispatcher;

  logic       clk;
  logic       ff_reset;
  logic [2:0] up_call, dn_call;
  logic [1:0] car0_floor, car0_ac, car1_floor, car1_ac;
  logic       car0_open, car0_ack, car1_open, car1_ack;
  logic       car0_valid, car0_dir_req, car1_valid, car1_dir_req;
  logic [1:0] car0_floor_req, car1_floor_req;
  logic [2:0] lamp_up, lamp_dn;

  int n_cmp = 0;
  int n_err = 0;

  hall_call_dispatcher dut (
    .clk              (clk),
    .ff_reset         (ff_reset),
    .i_up_call        (up_call),
    .i_dn_call        (dn_call),
    .i_car0_floor     (car0_floor),
    .i_car0_ac        (car0_ac),
    .i_car0_open      (car0_open),
    .i_car0_ack       (car0_ack),
    .i_car1_floor     (car1_floor),
    .i_car1_ac        (car1_ac),
    .i_car1_open      (car1_open),
    .i_car1_ack       (car1_ack),
    .o_car0_valid     (car0_valid),
    .o_car0_floor_req (car0_floor_req),
    .o_car0_dir_req   (car0_dir_req),
    .o_car1_valid     (car1_valid),
    .o_car1_floor_req (car1_floor_req),
    .o_car1_dir_req   (car1_dir_req),
    .o_lamp_up        (lamp_up),
    .o_lamp_dn        (lamp_dn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, landing 1 time unit after the last one
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    ff_reset   = 1'b1;
    up_call    = '0;
    dn_call    = '0;
    car0_floor = 2'd0;
    car0_ac    = 2'd1;
    car0_open  = 1'b0;
    car0_ack   = 1'b0;
    car1_floor = 2'd0;
    car1_ac    = 2'd1;
    car1_open  = 1'b0;
    car1_ack   = 1'b0;

    // Reset state
    step(2);
    check_eq("rst_valid0", 32'(car0_valid), 32'd0);
    check_eq("rst_valid1", 32'(car1_valid), 32'd0);
    check_eq("rst_floor", 32'(car0_floor_req), 32'd0);
    check_eq("rst_dir", 32'(car0_dir_req), 32'd0);
    check_eq("rst_lamps", 32'({lamp_dn, lamp_up}), 32'd0);
    ff_reset = 1'b0;
    step(1);

    // Both cars idle at floor 1, up call at floor 3: tie goes to car 0
    up_call = 3'b100;
    step(1);
    up_call = 3'b000;
    check_eq("t1_lamp", 32'(lamp_up), 32'b100);
    check_eq("t1_lat1", 32'(car0_valid), 32'd0);
    step(1);
    check_eq("t1_lat2", 32'(car0_valid), 32'd0);
    step(1);
    check_eq("t1_valid0", 32'(car0_valid), 32'd1);
    check_eq("t1_valid1", 32'(car1_valid), 32'd0);
    check_eq("t1_floor", 32'(car0_floor_req), 32'd2);
    check_eq("t1_dir", 32'(car0_dir_req), 32'd1);
    car0_ack = 1'b1;
    step(1);
    check_eq("t1_hold", 32'(car0_valid), 32'd1);
    step(1);
    car0_ack = 1'b0;
    check_eq("t1_ack_drop", 32'(car0_valid), 32'd0);
    check_eq("t1_lamp_kept", 32'(lamp_up), 32'b100);
    step(3);
    check_eq("t1_no_reoffer", 32'({car1_valid, car0_valid}), 32'd0);
    car0_floor = 2'd2;
    car0_open  = 1'b1;
    step(1);
    check_eq("t1_serviced", 32'(lamp_up), 32'd0);
    car0_floor = 2'd0;
    car0_open  = 1'b0;
    step(1);

    // Car0 at floor 4 going down, car1 at floor 1 going up, down call floor 2: car1 (1 vs 2)
    car0_floor = 2'd3;
    car0_ac    = 2'd0;
    car1_floor = 2'd0;
    car1_ac    = 2'd2;
    dn_call    = 3'b001;
    step(1);
    dn_call = 3'b000;
    step(2);
    check_eq("t2_valid1", 32'(car1_valid), 32'd1);
    check_eq("t2_valid0", 32'(car0_valid), 32'd0);
    check_eq("t2_floor", 32'(car1_floor_req), 32'd1);
    check_eq("t2_dir", 32'(car1_dir_req), 32'd0);
    step(1);

    // In WAIT, car1 stops open at floor 2 with a coincident ack that must be ignored
    car1_floor = 2'd1;
    car1_ac    = 2'd1;
    car1_open  = 1'b1;
    car1_ack   = 1'b1;
    step(1);
    check_eq("t3_withdraw", 32'(car1_valid), 32'd0);
    check_eq("t3_lamp_off", 32'(lamp_dn), 32'd0);
    car1_open = 1'b0;
    car1_ack  = 1'b0;
    step(3);
    check_eq("t3_quiet", 32'({car1_valid, car0_valid}), 32'd0);

    // Timeout: up call floor 2, tie goes to car1 (car0 served last), never acked
    car0_floor = 2'd0;
    car0_ac    = 2'd1;
    car1_floor = 2'd0;
    car1_ac    = 2'd1;
    up_call    = 3'b010;
    step(1);
    up_call = 3'b000;
    step(2);
    check_eq("t4_valid1", 32'(car1_valid), 32'd1);
    check_eq("t4_floor", 32'(car1_floor_req), 32'd1);
    check_eq("t4_dir", 32'(car1_dir_req), 32'd1);
    step(15);
    check_eq("t4_still", 32'(car1_valid), 32'd1);
    check_eq("t4_excl", 32'(car0_valid & car1_valid), 32'd0);
    step(1);
    check_eq("t4_timeout", 32'(car1_valid), 32'd0);
    check_eq("t4_pending", 32'(lamp_up), 32'b010);
    step(1);
    check_eq("t4_scan", 32'({car1_valid, car0_valid}), 32'd0);
    step(1);
    check_eq("t4_reoffer", 32'(car1_valid), 32'd1);
    check_eq("t4_refloor", 32'(car1_floor_req), 32'd1);

    // Reset pulsed during WAIT drops everything at once
    step(2);
    ff_reset = 1'b1;
    #1;
    check_eq("t5_valid", 32'({car1_valid, car0_valid}), 32'd0);
    check_eq("t5_lamps", 32'({lamp_dn, lamp_up}), 32'd0);
    check_eq("t5_floor", 32'(car1_floor_req), 32'd0);
    step(1);
    ff_reset = 1'b0;
    step(5);
    check_eq("t5_no_offer", 32'({car1_valid, car0_valid}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
